// File: rtl/alu_pkg.sv
// Shared definitions for the RV32IM integer execute unit: instruction-vector
// width, per-operation bit indices and M-extension operation codes.
package alu_pkg;

   localparam int unsigned INSTR_W = 48;

   // R-type
   localparam int unsigned ADD_B    = 0;
   localparam int unsigned SUB_B    = 1;
   localparam int unsigned XOR_B    = 2;
   localparam int unsigned OR_B     = 3;
   localparam int unsigned AND_B    = 4;
   localparam int unsigned SLL_B    = 5;
   localparam int unsigned SRL_B    = 6;
   localparam int unsigned SRA_B    = 7;
   localparam int unsigned SLT_B    = 8;
   localparam int unsigned SLTU_B   = 9;
   // I-type
   localparam int unsigned ADDI_B   = 10;
   localparam int unsigned XORI_B   = 11;
   localparam int unsigned ORI_B    = 12;
   localparam int unsigned ANDI_B   = 13;
   localparam int unsigned SLLI_B   = 14;
   localparam int unsigned SRLI_B   = 15;
   localparam int unsigned SRAI_B   = 16;
   localparam int unsigned SLTI_B   = 17;
   localparam int unsigned SLTIU_B  = 18;
   // M-extension
   localparam int unsigned MUL_B    = 40;
   localparam int unsigned MULH_B   = 41;
   localparam int unsigned MULHSU_B = 42;
   localparam int unsigned MULHU_B  = 43;
   localparam int unsigned DIV_B    = 44;
   localparam int unsigned DIVU_B   = 45;
   localparam int unsigned REM_B    = 46;
   localparam int unsigned REMU_B   = 47;

   localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

   // M-extension operation, ordered to match bits MUL_B..REMU_B
   typedef enum logic [2:0] {
      MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
      MD_DIV, MD_DIVU, MD_REM,    MD_REMU
   } md_op_t;

endpackage

// File: rtl/alu_muldiv.sv
// Combinational RV32M datapath: single-cycle multiply, divide and remainder.
module alu_muldiv
   import alu_pkg::*;
(
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  md_op_t      op,
   output logic [31:0] result
);

   logic [63:0] prod_ss, prod_su, prod_uu;
   logic [31:0] mag1, mag2, div_s, quo_s, rem_s, quo_u, rem_u;
   logic        div_zero;

   // Multiply, divide and result selection for the decoded M operation
   always_comb begin
      // Low 64 bits of an unsigned product of sign/zero-extended operands
      // equal the two's-complement product for every signedness mix.
      prod_ss = {{32{rs1[31]}}, rs1} * {{32{rs2[31]}}, rs2};
      prod_su = {{32{rs1[31]}}, rs1} * {32'b0, rs2};
      prod_uu = {32'b0, rs1} * {32'b0, rs2};

      div_zero = (rs2 == '0);
      div_s    = div_zero ? 32'd1 : rs2;

      // Signed division on magnitudes; the 0x80000000 / -1 overflow case
      // yields 0x80000000 rem 0 naturally through this path.
      mag1  = rs1[31] ? (~rs1 + 32'd1) : rs1;
      mag2  = div_s[31] ? (~div_s + 32'd1) : div_s;
      quo_s = mag1 / mag2;
      rem_s = mag1 % mag2;
      if (rs1[31] != div_s[31])
         quo_s = ~quo_s + 32'd1;
      if (rs1[31])
         rem_s = ~rem_s + 32'd1;

      quo_u = rs1 / div_s;
      rem_u = rs1 % div_s;

      result = '0;
      unique case (op)
         MD_MUL:    result = prod_ss[31:0];
         MD_MULH:   result = prod_ss[63:32];
         MD_MULHSU: result = prod_su[63:32];
         MD_MULHU:  result = prod_uu[63:32];
         MD_DIV:    result = div_zero ? DIV_BY_ZERO_Q : quo_s;
         MD_DIVU:   result = div_zero ? DIV_BY_ZERO_Q : quo_u;
         MD_REM:    result = div_zero ? rs1 : rem_s;
         MD_REMU:   result = div_zero ? rs1 : rem_u;
         default:   result = '0;
      endcase
   end

endmodule

// File: rtl/alu_unit.sv
// Registered RV32IM integer execute unit: one result per cycle selected by a
// one-hot decoded-instruction vector (lowest set bit wins), 1-cycle latency.
module alu_unit
   import alu_pkg::*;
#(
   parameter int unsigned INSTR_W = alu_pkg::INSTR_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [31:0]        rs1,
   input  logic [31:0]        rs2,
   input  logic [11:0]        imm,
   input  logic [INSTR_W-1:0] instructions,
   output logic [31:0]        ALUoutput
);

   logic [31:0] immx, md_result, result;
   logic        any_set;
   int unsigned sel;
   md_op_t      md_op;

   assign immx = {{20{imm[11]}}, imm};

   // Priority-select the lowest set instruction bit
   always_comb begin
      sel     = 0;
      any_set = 1'b0;
      for (int unsigned i = INSTR_W; i > 0; i--) begin
         if (instructions[i-1]) begin
            sel     = i - 1;
            any_set = 1'b1;
         end
      end
      md_op = md_op_t'(3'(sel - MUL_B));
   end

   alu_muldiv u_muldiv (
      .rs1    (rs1),
      .rs2    (rs2),
      .op     (md_op),
      .result (md_result)
   );

   // Base-integer operations and merge with the M-extension result
   always_comb begin
      result = '0;
      if (any_set) begin
         case (sel)
            ADD_B:    result = rs1 + rs2;
            SUB_B:    result = rs1 - rs2;
            XOR_B:    result = rs1 ^ rs2;
            OR_B:     result = rs1 | rs2;
            AND_B:    result = rs1 & rs2;
            SLL_B:    result = rs1 << rs2[4:0];
            SRL_B:    result = rs1 >> rs2[4:0];
            SRA_B:    result = $signed(rs1) >>> rs2[4:0];
            SLT_B:    result = {31'b0, $signed(rs1) < $signed(rs2)};
            SLTU_B:   result = {31'b0, rs1 < rs2};
            ADDI_B:   result = rs1 + immx;
            XORI_B:   result = rs1 ^ immx;
            ORI_B:    result = rs1 | immx;
            ANDI_B:   result = rs1 & immx;
            SLLI_B:   result = rs1 << imm[4:0];
            SRLI_B:   result = rs1 >> imm[4:0];
            SRAI_B:   result = $signed(rs1) >>> imm[4:0];
            SLTI_B:   result = {31'b0, $signed(rs1) < $signed(immx)};
            SLTIU_B:  result = {31'b0, rs1 < immx};
            MUL_B, MULH_B, MULHSU_B, MULHU_B,
            DIV_B, DIVU_B, REM_B, REMU_B:
                      result = md_result;
            default:  result = '0;
         endcase
      end
   end

   // Output register with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ALUoutput <= '0;
      else
         ALUoutput <= result;
   end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vector table, reset sequence,
// and randomized vectors checked against an arithmetic reference model.
module tb_alu_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] rs1, rs2;
   logic [11:0] imm;
   logic [47:0] instructions;
   logic [31:0] ALUoutput;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_unit #(.INSTR_W(48)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rs1          (rs1),
      .rs2          (rs2),
      .imm          (imm),
      .instructions (instructions),
      .ALUoutput    (ALUoutput)
   );

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [11:0] im;
      logic [47:0] ins;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [47:0] oh(input int k);
      logic [47:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   task automatic add(input string n, input logic [31:0] a, input logic [31:0] b,
                      input logic [11:0] im, input logic [47:0] ins, input logic [31:0] e);
      vec_t v;
      v.name = n; v.a = a; v.b = b; v.im = im; v.ins = ins; v.exp = e;
      vecs.push_back(v);
   endtask

   // Reference model: straight RISC-V semantics in 64-bit arithmetic
   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [11:0] im, input logic [47:0] ins);
      longint sa, sb, ua, ub, si, r;
      int k;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      si = longint'($signed(im));
      k = -1;
      for (int i = 47; i >= 0; i--)
         if (ins[i]) k = i;
      case (k)
         0:  r = sa + sb;
         1:  r = sa - sb;
         2:  r = ua ^ ub;
         3:  r = ua | ub;
         4:  r = ua & ub;
         5:  r = ua << b[4:0];
         6:  r = ua >> b[4:0];
         7:  r = sa >>> b[4:0];
         8:  r = (sa < sb) ? 1 : 0;
         9:  r = (ua < ub) ? 1 : 0;
         10: r = sa + si;
         11: r = ua ^ si;
         12: r = ua | si;
         13: r = ua & si;
         14: r = ua << im[4:0];
         15: r = ua >> im[4:0];
         16: r = sa >>> im[4:0];
         17: r = (sa < si) ? 1 : 0;
         18: r = (ua < (si & 64'hFFFF_FFFF)) ? 1 : 0;
         40: r = sa * sb;
         41: r = (sa * sb) >>> 32;
         42: r = (sa * ub) >>> 32;
         43: r = (ua * ub) >> 32;
         44: r = (b == 0) ? -1 : sa / sb;
         45: r = (b == 0) ? -1 : ua / ub;
         46: r = (b == 0) ? ua : sa % sb;
         47: r = (b == 0) ? ua : ua % ub;
         default: r = 0;
      endcase
      return r[31:0];
   endfunction

   task automatic check(input string n, input logic [31:0] exp);
      checks++;
      if (ALUoutput !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", n, ALUoutput, exp);
      end
   endtask

   // Drive on the falling edge, sample 1 ns after the next rising edge
   task automatic apply(input logic [31:0] a, input logic [31:0] b,
                        input logic [11:0] im, input logic [47:0] ins);
      @(negedge clk);
      rs1 = a; rs2 = b; imm = im; instructions = ins;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] a, b;
      logic [11:0] im;
      logic [47:0] ins;
      logic [31:0] corner[5];

      rst_n = 1'b0;
      rs1 = 32'd5; rs2 = 32'd4; imm = '0; instructions = oh(0);

      add("ADD", 5, 4, 0, oh(0), 9);
      add("SUB", 5, 4, 0, oh(1), 1);
      add("XOR", 5, 4, 0, oh(2), 1);
      add("OR", 5, 4, 0, oh(3), 5);
      add("AND", 5, 4, 0, oh(4), 4);
      add("SLL", 5, 4, 0, oh(5), 80);
      add("SRL", 5, 4, 0, oh(6), 0);
      add("SRA", 5, 4, 0, oh(7), 0);
      add("SLT", 5, 4, 0, oh(8), 0);
      add("SLTU", 5, 4, 0, oh(9), 0);
      add("ADDI", 5, 0, 12, oh(10), 17);
      add("XORI", 5, 0, 12, oh(11), 9);
      add("ORI", 5, 0, 12, oh(12), 13);
      add("ANDI", 5, 0, 12, oh(13), 4);
      add("SLLI", 5, 0, 12, oh(14), 20480);
      add("SRLI", 5, 0, 12, oh(15), 0);
      add("SRAI", 5, 0, 12, oh(16), 0);
      add("SLTI", 5, 0, 12, oh(17), 1);
      add("SLTIU", 5, 0, 12, oh(18), 1);
      add("SRA_neg", 32'hFFFF_FFF0, 4, 0, oh(7), 32'hFFFF_FFFF);
      add("SLT_neg", 32'hFFFF_FFF0, 4, 0, oh(8), 1);
      add("SLTU_neg", 32'hFFFF_FFF0, 4, 0, oh(9), 0);
      add("ADDI_negimm", 5, 0, 12'hFFF, oh(10), 4);
      add("SLTIU_negimm", 5, 0, 12'hFFF, oh(18), 1);
      add("MUL", 5, 4, 0, oh(40), 20);
      add("MULH", 5, 4, 0, oh(41), 0);
      add("MULHU", 5, 4, 0, oh(43), 0);
      add("DIV", 5, 4, 0, oh(44), 1);
      add("DIVU", 5, 4, 0, oh(45), 1);
      add("REM", 5, 4, 0, oh(46), 1);
      add("REMU", 5, 4, 0, oh(47), 1);
      add("MULHSU_neg", 32'hFFFF_FFFF, 2, 0, oh(42), 32'hFFFF_FFFF);
      add("MULHU_big", 32'hFFFF_FFFF, 2, 0, oh(43), 1);
      add("MULH_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, oh(41), 0);
      add("DIV_zero", 32'h1234_5678, 0, 0, oh(44), 32'hFFFF_FFFF);
      add("DIVU_zero", 32'h1234_5678, 0, 0, oh(45), 32'hFFFF_FFFF);
      add("REM_zero", 32'h1234_5678, 0, 0, oh(46), 32'h1234_5678);
      add("REMU_zero", 32'h1234_5678, 0, 0, oh(47), 32'h1234_5678);
      add("DIV_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 0, oh(44), 32'h8000_0000);
      add("REM_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 0, oh(46), 0);
      add("DIV_negtrunc", 32'hFFFF_FFF9, 2, 0, oh(44), 32'hFFFF_FFFD);
      add("REM_negsign", 32'hFFFF_FFF9, 2, 0, oh(46), 32'hFFFF_FFFF);
      add("none", 5, 4, 0, '0, 0);
      add("load_bit19", 5, 4, 0, oh(19), 0);
      add("jump_bit39", 5, 4, 0, oh(39), 0);
      add("multi_lowest", 5, 4, 0, oh(0) | oh(1) | oh(40), 9);
      add("multi_over_unused", 5, 4, 0, oh(1) | oh(25), 1);

      // Reset state, then first result one edge after release
      #3;
      check("reset_state", 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("first_add_after_reset", 32'd9);

      // Asynchronous reset asserted mid-cycle clears immediately and holds
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset_clear", 32'd0);
      @(posedge clk);
      #1;
      check("reset_hold_over_edge", 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("add_after_rerelease", 32'd9);

      // Directed vector table
      foreach (vecs[i]) begin
         apply(vecs[i].a, vecs[i].b, vecs[i].im, vecs[i].ins);
         check(vecs[i].name, vecs[i].exp);
      end

      // Randomized vectors against the reference model
      corner[0] = 32'h0000_0000;
      corner[1] = 32'h8000_0000;
      corner[2] = 32'hFFFF_FFFF;
      corner[3] = 32'h7FFF_FFFF;
      corner[4] = 32'h0000_0001;
      for (int n = 0; n < 400; n++) begin
         a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         im = 12'($urandom);
         case ($urandom_range(0, 9))
            0:       ins = '0;
            1:       ins = {16'($urandom), $urandom};
            default: ins = oh(int'($urandom_range(0, 47)));
         endcase
         apply(a, b, im, ins);
         check($sformatf("rand%0d", n), ref_alu(a, b, im, ins));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
